// File: rtl/decode_issue_ctrl.sv
// Decode-stage issue/hazard controller: per-register in-flight writer scoreboard,
// RAW/saturation stall generation and a branch wait/flush sequencer.
module decode_issue_ctrl #(
  parameter int unsigned NREG      = 16,
  parameter int unsigned CNT_W     = 2,
  parameter int unsigned FLUSH_CYC = 2,
  parameter int unsigned WB_BYPASS = 1,
  localparam int unsigned RW       = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [RW-1:0]   id_ra,
  input  logic [RW-1:0]   id_rb,
  input  logic            id_use_ra,
  input  logic            id_use_rb,
  input  logic [RW-1:0]   id_rd,
  input  logic            id_wr_rd,
  input  logic            id_is_branch,
  input  logic            br_resolved,
  input  logic            br_taken,
  input  logic            wb_we,
  input  logic [RW-1:0]   wb_rd,
  output logic            issue,
  output logic            stall_if,
  output logic            stall_id,
  output logic            flush_id,
  output logic [NREG-1:0] busy_mask
);

  localparam int unsigned FW = (FLUSH_CYC < 1) ? 1 : $clog2(FLUSH_CYC + 1);
  localparam logic [CNT_W-1:0] CntMax    = {CNT_W{1'b1}};
  localparam logic [FW-1:0]    FlushLoad = FW'(FLUSH_CYC);

  typedef enum logic [1:0] {StRun, StBrWait, StFlush} state_e;

  state_e           state_q, state_d;
  logic [FW-1:0]    fcnt_q, fcnt_d;
  logic [CNT_W-1:0] cnt_q [NREG];
  logic [CNT_W-1:0] cnt_d [NREG];

  logic [NREG-1:0] busy, pend, full, inc_v, dec_v;
  logic            raw_a, raw_b, sat;

  // Per-register status; a count-of-one being retired this cycle is not a hazard
  // when the writeback value can be bypassed.
  always_comb begin
    busy = '0;
    pend = '0;
    full = '0;
    for (int i = 0; i < NREG; i++) begin
      busy[i] = (cnt_q[i] != '0);
      full[i] = (cnt_q[i] == CntMax);
      pend[i] = busy[i] &&
                !((WB_BYPASS != 0) && wb_we && (wb_rd == RW'(i)) &&
                  (cnt_q[i] == CNT_W'(1)));
    end
  end

  assign raw_a     = id_use_ra && pend[id_ra];
  assign raw_b     = id_use_rb && pend[id_rb];
  assign sat       = id_wr_rd && full[id_rd];
  assign busy_mask = busy;

  always_comb begin
    state_d  = state_q;
    fcnt_d   = fcnt_q;
    issue    = 1'b0;
    stall_if = 1'b0;
    stall_id = 1'b0;
    flush_id = 1'b0;
    unique case (state_q)
      StRun: begin
        issue    = id_valid && !raw_a && !raw_b && !sat;
        stall_if = id_valid && !issue;
        stall_id = id_valid && !issue;
        if (issue && id_is_branch) begin
          state_d = StBrWait;
        end
      end
      StBrWait: begin
        stall_if = 1'b1;
        stall_id = 1'b1;
        if (br_resolved) begin
          if (br_taken) begin
            state_d = StFlush;
            fcnt_d  = FlushLoad;
          end else begin
            state_d = StRun;
          end
        end
      end
      StFlush: begin
        flush_id = 1'b1;
        if (fcnt_q <= FW'(1)) begin
          state_d = StRun;
          fcnt_d  = '0;
        end else begin
          fcnt_d = fcnt_q - FW'(1);
        end
      end
      default: begin
        state_d = StRun;
        fcnt_d  = '0;
      end
    endcase
    // Reset overrides everything, including the combinational handshake outputs.
    if (rst) begin
      issue    = 1'b0;
      stall_if = 1'b0;
      stall_id = 1'b0;
      flush_id = 1'b0;
    end
  end

  // A writeback to an idle register is spurious and leaves the count at zero.
  always_comb begin
    inc_v = '0;
    dec_v = '0;
    for (int i = 0; i < NREG; i++) begin
      inc_v[i] = issue && id_wr_rd && (id_rd == RW'(i));
      dec_v[i] = wb_we && (wb_rd == RW'(i)) && busy[i];
      cnt_d[i] = cnt_q[i];
      if (inc_v[i] && !dec_v[i]) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else if (dec_v[i] && !inc_v[i]) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StRun;
      fcnt_q  <= '0;
      for (int i = 0; i < NREG; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      for (int i = 0; i < NREG; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Directed bench for decode_issue_ctrl: a per-cycle reference model plus literal
// expectations at the key points of each scenario.
module tb_decode_issue_ctrl;

  localparam int NREG      = 16;
  localparam int FLUSH_CYC = 2;
  localparam int CMAX      = 3;
  localparam int MRun      = 0;
  localparam int MWait     = 1;
  localparam int MFlush    = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_use_ra, id_use_rb, id_wr_rd, id_is_branch;
  logic [3:0]  id_ra, id_rb, id_rd, wb_rd;
  logic        br_resolved, br_taken, wb_we;
  logic        issue, stall_if, stall_id, flush_id;
  logic [15:0] busy_mask;

  int nvec  = 0;
  int nfail = 0;

  int cnt_m [NREG];
  int mode_m;
  int left_m;
  bit model_ok = 1'b0;

  always #5 clk = ~clk;

  decode_issue_ctrl #(
    .NREG      (NREG),
    .CNT_W     (2),
    .FLUSH_CYC (FLUSH_CYC),
    .WB_BYPASS (1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_ra        (id_ra),
    .id_rb        (id_rb),
    .id_use_ra    (id_use_ra),
    .id_use_rb    (id_use_rb),
    .id_rd        (id_rd),
    .id_wr_rd     (id_wr_rd),
    .id_is_branch (id_is_branch),
    .br_resolved  (br_resolved),
    .br_taken     (br_taken),
    .wb_we        (wb_we),
    .wb_rd        (wb_rd),
    .issue        (issue),
    .stall_if     (stall_if),
    .stall_id     (stall_id),
    .flush_id     (flush_id),
    .busy_mask    (busy_mask)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    nvec++;
    if (got !== want) begin
      nfail++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  function automatic bit pend_m(input logic [3:0] r);
    return (cnt_m[r] > 0) && !(wb_we && (wb_rd == r) && (cnt_m[r] == 1));
  endfunction

  function automatic bit exp_issue();
    if (rst || mode_m != MRun || !id_valid) return 1'b0;
    if (id_use_ra && pend_m(id_ra)) return 1'b0;
    if (id_use_rb && pend_m(id_rb)) return 1'b0;
    if (id_wr_rd && cnt_m[id_rd] == CMAX) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit exp_stall();
    if (rst) return 1'b0;
    if (mode_m == MWait) return 1'b1;
    return (mode_m == MRun) && id_valid && !exp_issue();
  endfunction

  function automatic logic [15:0] exp_busy();
    logic [15:0] m;
    m = '0;
    for (int i = 0; i < NREG; i++) m[i] = (cnt_m[i] > 0);
    return m;
  endfunction

  // Reference model advances on each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        for (int i = 0; i < NREG; i++) cnt_m[i] = 0;
        mode_m   = MRun;
        left_m   = 0;
        model_ok = 1'b1;
      end else if (model_ok) begin
        bit iss;
        int old [NREG];
        iss = exp_issue();
        for (int i = 0; i < NREG; i++) old[i] = cnt_m[i];
        if (iss && id_wr_rd) cnt_m[id_rd] = cnt_m[id_rd] + 1;
        if (wb_we && old[wb_rd] > 0) cnt_m[wb_rd] = cnt_m[wb_rd] - 1;
        case (mode_m)
          MRun: if (iss && id_is_branch) mode_m = MWait;
          MWait: if (br_resolved) begin
            if (br_taken) begin
              mode_m = MFlush;
              left_m = FLUSH_CYC;
            end else begin
              mode_m = MRun;
            end
          end
          default: begin
            left_m = left_m - 1;
            if (left_m == 0) mode_m = MRun;
          end
        endcase
      end
    end
  end

  // Compare every output against the model on each falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (model_ok) begin
        chk("issue", 32'(issue), 32'(exp_issue()));
        chk("stall_if", 32'(stall_if), 32'(exp_stall()));
        chk("stall_id", 32'(stall_id), 32'(exp_stall()));
        chk("flush_id", 32'(flush_id), 32'(!rst && mode_m == MFlush));
        chk("busy_mask", 32'(busy_mask), 32'(exp_busy()));
      end
    end
  end

  task automatic apply(input bit r, input bit v, input int ra, input bit ua, input int rb,
                       input bit ub, input int rd, input bit wr, input bit br, input bit res,
                       input bit tk, input bit we, input int wrd);
    @(posedge clk);
    #1;
    rst          = r;
    id_valid     = v;
    id_ra        = 4'(ra);
    id_use_ra    = ua;
    id_rb        = 4'(rb);
    id_use_rb    = ub;
    id_rd        = 4'(rd);
    id_wr_rd     = wr;
    id_is_branch = br;
    br_resolved  = res;
    br_taken     = tk;
    wb_we        = we;
    wb_rd        = 4'(wrd);
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input bit we, input int wrd);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, we, wrd);
  endtask

  task automatic writer(input int rd, input bit we, input int wrd);
    apply(0, 1, 0, 0, 0, 0, rd, 1, 0, 0, 0, we, wrd);
  endtask

  task automatic plain(input bit res, input bit tk, input bit we, input int wrd);
    apply(0, 1, 4, 1, 0, 0, 0, 0, 0, res, tk, we, wrd);
  endtask

  initial begin
    rst = 1'b1; id_valid = 1'b0; id_ra = '0; id_rb = '0; id_rd = '0; wb_rd = '0;
    id_use_ra = 1'b0; id_use_rb = 1'b0; id_wr_rd = 1'b0; id_is_branch = 1'b0;
    br_resolved = 1'b0; br_taken = 1'b0; wb_we = 1'b0;

    // Reset held two cycles with a valid instruction present
    apply(1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("lit_rst_issue", 32'(issue), 0);
    chk("lit_rst_stall_if", 32'(stall_if), 0);
    chk("lit_rst_stall_id", 32'(stall_id), 0);
    chk("lit_rst_flush", 32'(flush_id), 0);
    chk("lit_rst_busy", 32'(busy_mask), 0);
    apply(1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("lit_rst2_issue", 32'(issue), 0);
    apply(0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("lit_post_rst_issue", 32'(issue), 1);

    // RAW on r8 resolved by a same-cycle writeback
    apply(0, 1, 1, 1, 3, 1, 8, 1, 0, 0, 0, 0, 0);
    chk("lit_add_issue", 32'(issue), 1);
    apply(0, 1, 8, 1, 0, 0, 9, 1, 0, 0, 0, 0, 0);
    chk("lit_raw_issue", 32'(issue), 0);
    chk("lit_raw_stall_if", 32'(stall_if), 1);
    chk("lit_raw_stall_id", 32'(stall_id), 1);
    chk("lit_raw_busy", 32'(busy_mask), 32'h0100);
    apply(0, 1, 8, 1, 0, 0, 9, 1, 0, 0, 0, 1, 8);
    chk("lit_bypass_issue", 32'(issue), 1);
    idle(0, 0);
    chk("lit_after_wb_busy", 32'(busy_mask), 32'h0200);
    idle(1, 9);

    // Simultaneous increment and decrement on r5
    writer(5, 0, 0);
    chk("lit_w5_busy_clear", 32'(busy_mask), 0);
    writer(5, 1, 5);
    chk("lit_w5_incdec_issue", 32'(issue), 1);
    idle(1, 5);
    chk("lit_r5_still_busy", 32'(busy_mask), 32'h0020);
    idle(1, 5);
    chk("lit_r5_clear", 32'(busy_mask), 0);
    idle(0, 0);
    chk("lit_r5_no_underflow", 32'(busy_mask), 0);

    // Saturation of r2
    for (int k = 0; k < 3; k++) begin
      writer(2, 0, 0);
      chk("lit_sat_fill_issue", 32'(issue), 1);
    end
    writer(2, 0, 0);
    chk("lit_sat_issue", 32'(issue), 0);
    chk("lit_sat_stall_if", 32'(stall_if), 1);
    chk("lit_sat_busy", 32'(busy_mask), 32'h0004);
    writer(2, 1, 2);
    writer(2, 0, 0);
    chk("lit_sat_release_issue", 32'(issue), 1);
    for (int k = 0; k < 3; k++) idle(1, 2);
    idle(0, 0);
    chk("lit_sat_drain_busy", 32'(busy_mask), 0);

    // Taken branch, writeback retired while waiting
    writer(7, 0, 0);
    apply(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    chk("lit_br_issue", 32'(issue), 1);
    plain(0, 0, 0, 0);
    chk("lit_wait1_issue", 32'(issue), 0);
    chk("lit_wait1_stall_if", 32'(stall_if), 1);
    chk("lit_wait1_stall_id", 32'(stall_id), 1);
    plain(0, 0, 1, 7);
    chk("lit_wait2_stall", 32'(stall_if), 1);
    plain(0, 0, 0, 0);
    chk("lit_wait3_stall", 32'(stall_id), 1);
    chk("lit_wait3_busy", 32'(busy_mask), 0);
    plain(1, 1, 0, 0);
    chk("lit_resolve_stall", 32'(stall_if), 1);
    plain(0, 0, 0, 0);
    chk("lit_flush1", 32'(flush_id), 1);
    chk("lit_flush1_issue", 32'(issue), 0);
    chk("lit_flush1_stall", 32'(stall_if), 0);
    plain(0, 0, 0, 0);
    chk("lit_flush2", 32'(flush_id), 1);
    plain(1, 1, 0, 0);
    chk("lit_flush_done", 32'(flush_id), 0);
    chk("lit_flush_done_issue", 32'(issue), 1);
    idle(0, 0);
    chk("lit_resolve_ignored", 32'(flush_id), 0);

    // Not-taken branch with link to r15
    apply(0, 1, 0, 0, 0, 0, 15, 1, 1, 0, 0, 0, 0);
    chk("lit_brl_issue", 32'(issue), 1);
    plain(0, 0, 0, 0);
    chk("lit_nt_wait", 32'(stall_if), 1);
    plain(1, 0, 0, 0);
    plain(0, 0, 0, 0);
    chk("lit_nt_issue", 32'(issue), 1);
    chk("lit_nt_noflush", 32'(flush_id), 0);
    chk("lit_nt_busy", 32'(busy_mask), 32'h8000);
    idle(1, 15);
    idle(0, 0);
    chk("lit_nt_drain", 32'(busy_mask), 0);

    // Reset during the first flush cycle
    apply(0, 1, 0, 0, 0, 0, 15, 1, 1, 0, 0, 0, 0);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    apply(1, 1, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    apply(0, 1, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("lit_midflush_flush", 32'(flush_id), 0);
    chk("lit_midflush_busy", 32'(busy_mask), 0);
    chk("lit_midflush_issue", 32'(issue), 1);
    idle(0, 0);
    chk("lit_midflush_run", 32'(flush_id), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
